cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Main FSM for the 4-way set-associative L1 cache. Sequences the tag/data/valid/dirty arrays and the PLRU unit between the CPU-side request port and the physical-memory (cacheline) port.
- Decides hit versus miss, dirty writeback, line allocation and PLRU update timing.
- Keeps saturating hit/miss performance counters.
- Pure control block: all arrays and way selection stay in the datapath; this block only issues load/select strobes.

Parameters:
- CNT_W, 32, width of the hit and miss performance counters (saturating).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp; never asserted together with mem_read
- mem_resp  out  1  one-cycle completion pulse to the CPU
- hit  in  1  datapath: tag match in some valid way of the indexed set
- dirty_sel  in  1  datapath: dirty bit of the way currently chosen by the PLRU unit
- valid_sel  in  1  datapath: valid bit of the chosen way
- pmem_read  out  1  cacheline read request to memory; held until pmem_resp
- pmem_write  out  1  cacheline write request to memory; held until pmem_resp
- pmem_resp  in  1  memory completion pulse
- load_plru  out  1  strobe: update PLRU state for the current set and way
- load_tag  out  1  write the tag of the chosen way
- load_valid  out  1  set the valid bit of the chosen way
- load_data  out  1  write the data array of the chosen way
- data_in_sel  out  1  0 = data from the CPU (byte-enabled write), 1 = line from pmem
- set_dirty  out  1  set the dirty bit of the chosen way
- clr_dirty  out  1  clear the dirty bit of the chosen way
- pmem_addr_sel  out  1  0 = CPU address (fill), 1 = {victim tag, index} (writeback)
- hit_count  out  CNT_W  completed requests that hit
- miss_count  out  CNT_W  requests that missed

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL_DONE. Encoding is a 3-bit enum.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Counters=0.
  - All outputs 0 while in reset and in IDLE.
- IDLE -> COMPARE when mem_read|mem_write; otherwise stay.
- COMPARE, hit=1:
  - mem_resp=1 and load_plru=1 (same cycle).
  - On write: also load_data=1, data_in_sel=0, set_dirty=1.
  - hit_count increments.
  - Next state: IDLE.
  - Hit latency is 2 cycles from request assertion to mem_resp.
- COMPARE, hit=0:
  - miss_count increments exactly once per request, in this cycle only.
  - If valid_sel & dirty_sel, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - pmem_write=1 and pmem_addr_sel=1, held each cycle.
  - On pmem_resp: clr_dirty=1 and go to ALLOCATE. Otherwise stay.
- ALLOCATE:
  - pmem_read=1 and pmem_addr_sel=0, held each cycle.
  - On pmem_resp, in the same cycle: load_data=1, data_in_sel=1, load_tag=1, load_valid=1, clr_dirty=1. Then go to REFILL_DONE.
- REFILL_DONE: go to COMPARE without any output. The replay then hits, and the PLRU update, any write merge and mem_resp happen there. The replay does not increment hit_count.
- Counters saturate at all-ones; they never wrap.
- Simultaneous pmem_read and pmem_write is illegal and never driven.
- mem_resp is never asserted outside COMPARE.
- A pmem_resp arriving in IDLE/COMPARE/REFILL_DONE is ignored.
- CPU request dropped mid-miss: the FSM still completes the fill and returns to IDLE via COMPARE. In COMPARE with no request it goes to IDLE with no mem_resp and no counter change.
- Reset mid-operation:
  - Immediate return to IDLE and deassertion of all pmem strobes.
  - Memory must tolerate an abandoned transaction.
- All outputs are combinational functions of state and inputs (Moore/Mealy mix as listed). Only state and counters are registered.

Decomposition:
- Package cache_types_pkg holds:
  - the state enum (cache_state_t);
  - the data_in_sel and pmem_addr_sel mux encodings (DIN_CPU/DIN_PMEM, PADDR_CPU/PADDR_WB);
  - the counter width default.
- One natural sub-module: perf_counter, a saturating CNT_W up-counter with async active-low reset and an inc strobe. It is instantiated twice.
- The FSM itself stays in cache_ctrl.

Test Plan:
- Read hit: reset, then mem_read=1 with hit=1 -> mem_resp and load_plru high in cycle 2; hit_count=1, miss_count=0; no pmem strobe.
- Clean read miss: hit=0, valid_sel=1, dirty_sel=0; pmem_resp after 5 cycles; hit=1 on replay -> pmem_read held 5 cycles; load_data/load_tag/load_valid with data_in_sel=1 on the pmem_resp cycle; mem_resp at cycle 9; miss_count=1, hit_count=0.
- Dirty write miss: valid_sel=1, dirty_sel=1, mem_write -> pmem_write with pmem_addr_sel=1 until pmem_resp; then clr_dirty; then pmem_read with pmem_addr_sel=0. On the replay: set_dirty=1, load_data=1, data_in_sel=0, mem_resp=1.
- Saturation: preload counters to all-ones via forced hits (CNT_W=4 override, 20 hits) -> hit_count stays 15, never 0.
- Reset mid-writeback: drive rst=0 for 1 cycle while pmem_write=1 -> pmem_write drops asynchronously; state=IDLE; counters=0.
- Request withdrawn during ALLOCATE: deassert mem_read, then pmem_resp -> fill strobes fire, FSM returns to IDLE, mem_resp never asserted.

Source files
------------

// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared state encoding, mux selects and counter width for the L1 cache controller.
package cache_types_pkg;
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        COMPARE     = 3'd1,
        WRITEBACK   = 3'd2,
        ALLOCATE    = 3'd3,
        REFILL_DONE = 3'd4
    } cache_state_t;

    localparam logic DIN_CPU   = 1'b0;
    localparam logic DIN_PMEM  = 1'b1;
    localparam logic PADDR_CPU = 1'b0;
    localparam logic PADDR_WB  = 1'b1;

    localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: saturating up-counter with async active-low reset.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: main FSM of the 4-way L1 cache; issues array/PLRU strobes and pmem requests.
module cache_ctrl
    import cache_types_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             dirty_sel,
    input  logic             valid_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic             load_plru,
    output logic             load_tag,
    output logic             load_valid,
    output logic             load_data,
    output logic             data_in_sel,
    output logic             set_dirty,
    output logic             clr_dirty,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    cache_state_t state;
    logic         replay;
    logic         req, cmp, wb, alloc, fill, hit_inc, miss_inc;

    assign req   = mem_read | mem_write;
    assign cmp   = state == COMPARE;
    assign wb    = state == WRITEBACK;
    assign alloc = state == ALLOCATE;
    assign fill  = alloc & pmem_resp;

    assign mem_resp      = cmp & req & hit;
    assign load_plru     = mem_resp;
    assign set_dirty     = mem_resp & mem_write;
    assign load_data     = set_dirty | fill;
    assign data_in_sel   = fill ? DIN_PMEM : DIN_CPU;
    assign load_tag      = fill;
    assign load_valid    = fill;
    assign clr_dirty     = (wb | alloc) & pmem_resp;
    assign pmem_write    = wb;
    assign pmem_read     = alloc;
    assign pmem_addr_sel = wb ? PADDR_WB : PADDR_CPU;

    // The post-refill replay is the same request, so it must not be counted again.
    assign hit_inc  = mem_resp & ~replay;
    assign miss_inc = cmp & req & ~hit & ~replay;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            replay <= 1'b0;
        end else begin
            case (state)
                IDLE:        if (req) state <= COMPARE;
                COMPARE:
                    if (!req || hit) begin
                        state  <= IDLE;
                        replay <= 1'b0;
                    end else
                        state <= (valid_sel && dirty_sel) ? WRITEBACK : ALLOCATE;
                WRITEBACK:   if (pmem_resp) state <= ALLOCATE;
                ALLOCATE:    if (pmem_resp) state <= REFILL_DONE;
                REFILL_DONE: begin
                    state  <= COMPARE;
                    replay <= 1'b1;
                end
                default:     state <= IDLE;
            endcase
        end

    perf_counter #(.W(CNT_W)) u_hit_cnt  (.clk(clk), .rst(rst), .inc(hit_inc),  .count(hit_count));
    perf_counter #(.W(CNT_W)) u_miss_cnt (.clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count));
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl with 4-bit counters.
module tb_cache_ctrl;
    logic clk = 1'b0, rst = 1'b0;
    logic mem_read = 0, mem_write = 0, hit = 0, dirty_sel = 0, valid_sel = 0, pmem_resp = 0;
    logic mem_resp, pmem_read, pmem_write, load_plru, load_tag, load_valid, load_data;
    logic data_in_sel, set_dirty, clr_dirty, pmem_addr_sel;
    logic [3:0] hit_count, miss_count;
    int checks = 0, failures = 0;
    int exp_hits;

    always #5 clk = ~clk;

    cache_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .dirty_sel(dirty_sel), .valid_sel(valid_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp), .load_plru(load_plru), .load_tag(load_tag),
        .load_valid(load_valid), .load_data(load_data), .data_in_sel(data_in_sel),
        .set_dirty(set_dirty), .clr_dirty(clr_dirty), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic all_quiet(input string tag);
        chk(tag, {mem_resp, pmem_read, pmem_write, load_plru, load_tag, load_valid, load_data,
                  data_in_sel, set_dirty, clr_dirty, pmem_addr_sel}, 32'd0);
    endtask

    // Two-cycle read hit starting from IDLE; leaves the FSM in IDLE with no request.
    task automatic read_hit(input string tag);
        cyc(); mem_read = 1; hit = 1; #3;
        chk({tag, "_idle_resp"}, mem_resp, 0);
        cyc(); #3;
        chk({tag, "_resp"}, mem_resp, 1);
        chk({tag, "_plru"}, load_plru, 1);
        cyc(); mem_read = 0; hit = 0;
    endtask

    initial begin
        #23;
        all_quiet("reset_outputs");
        chk("reset_hits", hit_count, 0);
        chk("reset_miss", miss_count, 0);
        cyc(); rst = 1; mem_read = 1; hit = 1; #3;
        // read hit
        all_quiet("idle_outputs");
        cyc(); #3;
        chk("rh_resp", mem_resp, 1);
        chk("rh_plru", load_plru, 1);
        chk("rh_no_pmem", {pmem_read, pmem_write, set_dirty, load_data}, 0);
        cyc(); mem_read = 0; hit = 0; #3;
        chk("rh_hits", hit_count, 1);
        chk("rh_miss", miss_count, 0);
        chk("rh_resp_gone", mem_resp, 0);
        // clean read miss
        mem_read = 1; valid_sel = 1; dirty_sel = 0; #1;
        cyc(); #3;
        chk("cm_cmp_resp", mem_resp, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); pmem_resp = (i == 4); #3;
            chk("cm_pread", pmem_read, 1);
            chk("cm_paddr", pmem_addr_sel, 0);
            chk("cm_pwrite", pmem_write, 0);
            chk("cm_fill", {load_data, load_tag, load_valid, data_in_sel, clr_dirty}, (i == 4) ? 5'h1f : 5'h0);
        end
        chk("cm_miss", miss_count, 1);
        cyc(); pmem_resp = 0; hit = 1; #3;
        all_quiet("cm_refill_done");
        cyc(); #3;
        chk("cm_replay_resp", mem_resp, 1);
        chk("cm_replay_plru", load_plru, 1);
        cyc(); mem_read = 0; hit = 0; #3;
        chk("cm_hits", hit_count, 1);
        chk("cm_miss2", miss_count, 1);
        // dirty write miss
        mem_write = 1; dirty_sel = 1; #1;
        cyc(); #3;
        cyc(); #3;
        chk("dw_pwrite", pmem_write, 1);
        chk("dw_paddr", pmem_addr_sel, 1);
        chk("dw_pread", pmem_read, 0);
        chk("dw_clr_early", clr_dirty, 0);
        chk("dw_miss", miss_count, 2);
        cyc(); pmem_resp = 1; #3;
        chk("dw_clr", clr_dirty, 1);
        chk("dw_no_tag", load_tag, 0);
        cyc(); pmem_resp = 0; #3;
        chk("dw_alloc", {pmem_read, pmem_write, pmem_addr_sel}, 3'b100);
        pmem_resp = 1; #1;
        chk("dw_fill", {load_data, load_tag, load_valid, data_in_sel}, 4'hf);
        cyc(); pmem_resp = 0; hit = 1; #3;
        cyc(); #3;
        chk("dw_replay", {mem_resp, set_dirty, load_data, data_in_sel, load_plru}, 5'b11101);
        cyc(); mem_write = 0; hit = 0; #3;
        chk("dw_hits", hit_count, 1);
        chk("dw_miss2", miss_count, 2);
        // request withdrawn during ALLOCATE
        mem_read = 1; valid_sel = 0; #1;
        cyc(); #3;
        cyc(); mem_read = 0; #3;
        chk("wd_pread", pmem_read, 1);
        chk("wd_miss", miss_count, 3);
        cyc(); pmem_resp = 1; #3;
        chk("wd_fill", {load_data, load_tag, load_valid}, 3'b111);
        cyc(); pmem_resp = 0; hit = 1; #3;
        chk("wd_rd_resp", mem_resp, 0);
        cyc(); #3;
        chk("wd_cmp_resp", mem_resp, 0);
        cyc(); hit = 0; #3;
        all_quiet("wd_idle");
        chk("wd_hits", hit_count, 1);
        chk("wd_miss2", miss_count, 3);
        read_hit("wd_after");
        #3;
        chk("wd_after_hits", hit_count, 2);
        // reset during writeback
        mem_write = 1; valid_sel = 1; dirty_sel = 1; #1;
        cyc(); #3;
        cyc(); #3;
        chk("rw_pwrite", pmem_write, 1);
        rst = 0; #1;
        chk("rw_async_drop", pmem_write, 0);
        all_quiet("rw_reset_outputs");
        chk("rw_hits", hit_count, 0);
        chk("rw_miss", miss_count, 0);
        mem_write = 0; dirty_sel = 0; valid_sel = 0;
        cyc(); rst = 1; #3;
        all_quiet("rw_idle");
        read_hit("rw_after");
        #3;
        chk("rw_after_hits", hit_count, 1);
        // hit counter saturation
        exp_hits = 1;
        for (int i = 0; i < 20; i++) begin
            read_hit("sat");
            #3;
            exp_hits = (exp_hits < 15) ? exp_hits + 1 : 15;
            chk("sat_hits", hit_count, exp_hits);
        end
        chk("sat_final", hit_count, 15);
        chk("sat_miss", miss_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
